// File: rtl/rob_banked.sv
// Banked reorder buffer: one row of BANKS lanes per dispatch group, in-order row commit,
// multi-port writeback, precise exception capture and external flush.
module rob_banked #(
    parameter int ROB_DEPTH = 16,
    parameter int BANKS     = 2,
    parameter int WB_PORTS  = 3,
    parameter int PHYS_W    = 8,
    parameter int ARCH_W    = 5,
    localparam int ROW_W    = $clog2(ROB_DEPTH),
    localparam int BANK_W   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BANKS-1:0]           dispatch_valid,
    output logic                       dispatch_ready,
    input  logic [BANKS*PHYS_W-1:0]    dispatch_phys_rd,
    input  logic [BANKS*ARCH_W-1:0]    dispatch_arch_rd,
    output logic [ROW_W-1:0]           dispatch_rob_addr,
    input  logic [WB_PORTS-1:0]        wb_en,
    input  logic [WB_PORTS*ROW_W-1:0]  wb_rob_addr,
    input  logic [WB_PORTS*BANK_W-1:0] wb_bank,
    input  logic [WB_PORTS-1:0]        wb_exception,
    output logic [BANKS-1:0]           commit_en,
    output logic [BANKS*PHYS_W-1:0]    commit_phys_rd,
    output logic [BANKS*ARCH_W-1:0]    commit_arch_rd,
    input  logic                       flush_in,
    output logic                       exc_flush,
    output logic [BANK_W-1:0]          exc_bank,
    output logic                       empty,
    output logic [ROW_W:0]             num_rows
);

    logic [BANKS-1:0]        r_valid [ROB_DEPTH];
    logic [BANKS-1:0]        r_done  [ROB_DEPTH];
    logic [BANKS-1:0]        r_exc   [ROB_DEPTH];
    logic [PHYS_W-1:0]       r_phys  [ROB_DEPTH][BANKS];
    logic [ARCH_W-1:0]       r_arch  [ROB_DEPTH][BANKS];
    logic [ROW_W-1:0]        r_head;
    logic [ROW_W-1:0]        r_tail;
    logic [ROW_W:0]          r_num_rows;
    logic [BANKS-1:0]        r_commit_en;
    logic [BANKS*PHYS_W-1:0] r_commit_phys;
    logic [BANKS*ARCH_W-1:0] r_commit_arch;
    logic                    r_exc_wait;
    logic                    r_exc_flush;
    logic [BANK_W-1:0]       r_exc_k;
    logic [BANK_W-1:0]       r_exc_bank;

    logic [BANKS-1:0]        w_wb_done [ROB_DEPTH];
    logic [BANKS-1:0]        w_wb_exc  [ROB_DEPTH];
    logic                    w_ready;
    logic                    w_flush;
    logic                    w_flush_pending;
    logic                    w_fire;
    logic                    w_exc_hit;
    logic [BANK_W-1:0]       w_exc_k;
    logic                    w_below_ok;
    logic                    w_all_done;
    logic [BANKS-1:0]        w_commit_mask;
    logic                    w_commit;
    logic                    w_commit_norm;

    assign w_ready         = (r_num_rows != (ROW_W+1)'(ROB_DEPTH));
    assign w_flush_pending = r_exc_wait | r_exc_flush;
    assign w_flush         = flush_in | r_exc_flush;
    assign w_fire          = (|dispatch_valid) && w_ready && !w_flush_pending;

    // Merge all writeback ports per entry first so two ports on one entry OR their exc bits.
    always_comb begin
        for (int unsigned r = 0; r < ROB_DEPTH; r++) begin
            w_wb_done[ROW_W'(r)] = '0;
            w_wb_exc[ROW_W'(r)]  = '0;
        end
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_en[p] && (int'(wb_bank[p*BANK_W +: BANK_W]) < BANKS)) begin
                w_wb_done[wb_rob_addr[p*ROW_W +: ROW_W]][wb_bank[p*BANK_W +: BANK_W]] = 1'b1;
                w_wb_exc[wb_rob_addr[p*ROW_W +: ROW_W]][wb_bank[p*BANK_W +: BANK_W]] =
                    w_wb_exc[wb_rob_addr[p*ROW_W +: ROW_W]][wb_bank[p*BANK_W +: BANK_W]] | wb_exception[p];
            end
        end
    end

    // Lanes below the first excepting lane form the committable prefix of the head row.
    always_comb begin
        w_exc_hit     = 1'b0;
        w_exc_k       = '0;
        w_below_ok    = 1'b1;
        w_all_done    = 1'b1;
        w_commit_mask = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (r_valid[r_head][BANK_W'(b)] && !r_done[r_head][BANK_W'(b)])
                w_all_done = 1'b0;
            if (!w_exc_hit) begin
                if (r_valid[r_head][BANK_W'(b)] && r_done[r_head][BANK_W'(b)] && r_exc[r_head][BANK_W'(b)]) begin
                    w_exc_hit = 1'b1;
                    w_exc_k   = BANK_W'(b);
                end else begin
                    if (r_valid[r_head][BANK_W'(b)] && !r_done[r_head][BANK_W'(b)])
                        w_below_ok = 1'b0;
                    w_commit_mask[BANK_W'(b)] = r_valid[r_head][BANK_W'(b)];
                end
            end
        end
    end

    assign w_commit      = (r_num_rows != '0) && !w_flush_pending && (w_exc_hit ? w_below_ok : w_all_done);
    assign w_commit_norm = w_commit && !w_exc_hit;

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int unsigned b = 0; b < BANKS; b++) begin
                r_phys[r_tail][BANK_W'(b)] <= dispatch_phys_rd[b*PHYS_W +: PHYS_W];
                r_arch[r_tail][BANK_W'(b)] <= dispatch_arch_rd[b*ARCH_W +: ARCH_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < ROB_DEPTH; r++) begin
                r_valid[ROW_W'(r)] <= '0;
                r_done[ROW_W'(r)]  <= '0;
                r_exc[ROW_W'(r)]   <= '0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_num_rows    <= '0;
            r_commit_en   <= '0;
            r_commit_phys <= '0;
            r_commit_arch <= '0;
            r_exc_wait    <= 1'b0;
            r_exc_flush   <= 1'b0;
            r_exc_k       <= '0;
            r_exc_bank    <= '0;
        end else if (w_flush) begin
            for (int unsigned r = 0; r < ROB_DEPTH; r++) begin
                r_valid[ROW_W'(r)] <= '0;
                r_done[ROW_W'(r)]  <= '0;
                r_exc[ROW_W'(r)]   <= '0;
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_num_rows  <= '0;
            r_commit_en <= '0;
            r_exc_wait  <= 1'b0;
            r_exc_flush <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < ROB_DEPTH; r++) begin
                r_done[ROW_W'(r)] <= r_done[ROW_W'(r)] | (w_wb_done[ROW_W'(r)] & r_valid[ROW_W'(r)]);
                r_exc[ROW_W'(r)]  <= r_exc[ROW_W'(r)]  | (w_wb_exc[ROW_W'(r)]  & r_valid[ROW_W'(r)]);
            end
            r_commit_en <= '0;
            r_exc_wait  <= 1'b0;
            r_exc_flush <= r_exc_wait;
            if (r_exc_wait)
                r_exc_bank <= r_exc_k;
            if (w_commit) begin
                r_commit_en <= w_commit_mask;
                for (int unsigned b = 0; b < BANKS; b++) begin
                    r_commit_phys[b*PHYS_W +: PHYS_W] <= r_phys[r_head][BANK_W'(b)];
                    r_commit_arch[b*ARCH_W +: ARCH_W] <= r_arch[r_head][BANK_W'(b)];
                end
                // A partial (exception) commit leaves the row in place; the flush that follows clears it.
                if (w_exc_hit) begin
                    r_exc_wait <= 1'b1;
                    r_exc_k    <= w_exc_k;
                end else begin
                    r_valid[r_head] <= '0;
                    r_done[r_head]  <= '0;
                    r_exc[r_head]   <= '0;
                    r_head          <= r_head + ROW_W'(1);
                end
            end
            if (w_fire) begin
                r_valid[r_tail] <= dispatch_valid;
                r_done[r_tail]  <= '0;
                r_exc[r_tail]   <= '0;
                r_tail          <= r_tail + ROW_W'(1);
            end
            if (w_fire && !w_commit_norm)
                r_num_rows <= r_num_rows + (ROW_W+1)'(1);
            else if (!w_fire && w_commit_norm)
                r_num_rows <= r_num_rows - (ROW_W+1)'(1);
        end
    end

    assign dispatch_ready    = w_ready;
    assign dispatch_rob_addr = r_tail;
    assign commit_en         = r_commit_en;
    assign commit_phys_rd    = r_commit_phys;
    assign commit_arch_rd    = r_commit_arch;
    assign exc_flush         = r_exc_flush;
    assign exc_bank          = r_exc_bank;
    assign empty             = (r_num_rows == '0);
    assign num_rows          = r_num_rows;

endmodule

// File: tb/tb_rob_banked.sv
// Directed bench for rob_banked at DEPTH=4, BANKS=2, WB_PORTS=3 with hand-computed expectations.
module tb_rob_banked;

    localparam int DEPTH = 4;
    localparam int BANKS = 2;
    localparam int WBP   = 3;
    localparam int PW    = 8;
    localparam int AW    = 5;
    localparam int RW    = 2;
    localparam int BW    = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [BANKS-1:0]    dispatch_valid;
    logic                dispatch_ready;
    logic [BANKS*PW-1:0] dispatch_phys_rd;
    logic [BANKS*AW-1:0] dispatch_arch_rd;
    logic [RW-1:0]       dispatch_rob_addr;
    logic [WBP-1:0]      wb_en;
    logic [WBP*RW-1:0]   wb_rob_addr;
    logic [WBP*BW-1:0]   wb_bank;
    logic [WBP-1:0]      wb_exception;
    logic [BANKS-1:0]    commit_en;
    logic [BANKS*PW-1:0] commit_phys_rd;
    logic [BANKS*AW-1:0] commit_arch_rd;
    logic                flush_in;
    logic                exc_flush;
    logic [BW-1:0]       exc_bank;
    logic                empty;
    logic [RW:0]         num_rows;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    rob_banked #(.ROB_DEPTH(DEPTH), .BANKS(BANKS), .WB_PORTS(WBP), .PHYS_W(PW), .ARCH_W(AW)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_phys_rd(dispatch_phys_rd), .dispatch_arch_rd(dispatch_arch_rd),
        .dispatch_rob_addr(dispatch_rob_addr),
        .wb_en(wb_en), .wb_rob_addr(wb_rob_addr), .wb_bank(wb_bank), .wb_exception(wb_exception),
        .commit_en(commit_en), .commit_phys_rd(commit_phys_rd), .commit_arch_rd(commit_arch_rd),
        .flush_in(flush_in), .exc_flush(exc_flush), .exc_bank(exc_bank),
        .empty(empty), .num_rows(num_rows)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_valid   = '0;
        dispatch_phys_rd = '0;
        dispatch_arch_rd = '0;
        wb_en            = '0;
        wb_rob_addr      = '0;
        wb_bank          = '0;
        wb_exception     = '0;
        flush_in         = 1'b0;
    endtask

    task automatic disp(input logic [1:0] v, input logic [7:0] p1, input logic [7:0] p0,
                        input logic [4:0] a1, input logic [4:0] a0);
        dispatch_valid   = v;
        dispatch_phys_rd = {p1, p0};
        dispatch_arch_rd = {a1, a0};
    endtask

    task automatic wbset(input int port, input int row, input int lane, input logic exc);
        wb_en[port]                = 1'b1;
        wb_rob_addr[port*RW +: RW] = row[RW-1:0];
        wb_bank[port*BW +: BW]     = lane[BW-1:0];
        wb_exception[port]         = exc;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #3;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(dispatch_ready), 1);
        chk("rst_num", 32'(num_rows), 0);
        chk("rst_cen", 32'(commit_en), 0);
        chk("rst_excf", 32'(exc_flush), 0);
        chk("rst_addr", 32'(dispatch_rob_addr), 0);
        #9 rst = 1'b1;

        // Fill all four rows, then one rejected attempt at full.
        disp(2'b11, 8'h01, 8'h00, 5'd1, 5'd0); chk("addr0", 32'(dispatch_rob_addr), 0); tick();
        disp(2'b01, 8'h11, 8'h10, 5'd3, 5'd2); chk("addr1", 32'(dispatch_rob_addr), 1); tick();
        disp(2'b11, 8'h21, 8'h20, 5'd5, 5'd4); chk("addr2", 32'(dispatch_rob_addr), 2); tick();
        disp(2'b11, 8'h31, 8'h30, 5'd7, 5'd6); chk("addr3", 32'(dispatch_rob_addr), 3); tick();
        chk("num_full", 32'(num_rows), 4);
        chk("ready_full", 32'(dispatch_ready), 0);
        chk("addr_wrap", 32'(dispatch_rob_addr), 0);
        chk("notempty", 32'(empty), 0);
        disp(2'b11, 8'hA1, 8'hA0, 5'd11, 5'd10); tick();
        chk("num_reject", 32'(num_rows), 4);
        chk("addr_reject", 32'(dispatch_rob_addr), 0);

        // Out-of-order writeback on row 0; commit only after lane 0 completes.
        idle(); wbset(0, 0, 1, 1'b0); tick();
        idle(); tick();
        chk("cen_partial", 32'(commit_en), 0);
        wbset(0, 0, 0, 1'b0); tick();
        chk("cen_wb_cycle", 32'(commit_en), 0);
        idle(); disp(2'b11, 8'hB1, 8'hB0, 5'd13, 5'd12);
        chk("ready_at_full", 32'(dispatch_ready), 0);
        tick();
        chk("cen_row0", 32'(commit_en), 3);
        chk("phys_row0", 32'(commit_phys_rd), 32'h0100);
        chk("arch_row0", 32'(commit_arch_rd), 32'h020);
        chk("num_after_commit", 32'(num_rows), 3);
        chk("addr_after_commit", 32'(dispatch_rob_addr), 0);
        tick();
        chk("num_refill", 32'(num_rows), 4);
        chk("addr_refill", 32'(dispatch_rob_addr), 1);
        chk("cen_row1_wait", 32'(commit_en), 0);

        // Row 1 holds a single valid lane.
        idle(); wbset(0, 1, 0, 1'b0); tick();
        idle(); tick();
        chk("cen_row1", 32'(commit_en), 1);
        chk("phys_row1", 32'(commit_phys_rd[7:0]), 32'h10);
        chk("arch_row1", 32'(commit_arch_rd[4:0]), 2);
        chk("num_row1", 32'(num_rows), 3);

        // flush_in with a ready head row and a presented group.
        wbset(0, 2, 0, 1'b0); wbset(1, 2, 1, 1'b0); tick();
        chk("cen_pre_flush", 32'(commit_en), 0);
        idle(); flush_in = 1'b1; disp(2'b11, 8'hC1, 8'hC0, 5'd15, 5'd14);
        chk("ready_pre_flush", 32'(dispatch_ready), 1);
        tick();
        chk("cen_flush", 32'(commit_en), 0);
        chk("empty_flush", 32'(empty), 1);
        chk("num_flush", 32'(num_rows), 0);
        chk("addr_flush", 32'(dispatch_rob_addr), 0);
        idle(); tick();
        chk("cen_post_flush", 32'(commit_en), 0);
        chk("empty_post_flush", 32'(empty), 1);

        // Exception on lane 1 of the head row, two ports in one cycle.
        disp(2'b11, 8'h51, 8'h50, 5'd17, 5'd16); tick();
        disp(2'b11, 8'h61, 8'h60, 5'd19, 5'd18); tick();
        idle(); wbset(0, 0, 0, 1'b0); wbset(1, 0, 1, 1'b1); tick();
        chk("cen_exc_wb", 32'(commit_en), 0);
        idle(); tick();
        chk("cen_exc", 32'(commit_en), 1);
        chk("phys_exc", 32'(commit_phys_rd[7:0]), 32'h50);
        chk("arch_exc", 32'(commit_arch_rd[4:0]), 16);
        chk("excf_early", 32'(exc_flush), 0);
        chk("addr_exc", 32'(dispatch_rob_addr), 2);
        disp(2'b11, 8'h71, 8'h70, 5'd21, 5'd20); tick();
        chk("excf_pulse", 32'(exc_flush), 1);
        chk("exc_bank", 32'(exc_bank), 1);
        chk("cen_excf", 32'(commit_en), 0);
        chk("addr_blocked", 32'(dispatch_rob_addr), 2);
        idle(); tick();
        chk("excf_end", 32'(exc_flush), 0);
        chk("empty_exc", 32'(empty), 1);
        chk("num_exc", 32'(num_rows), 0);
        chk("addr_exc_done", 32'(dispatch_rob_addr), 0);

        // Three simultaneous writebacks, then a write to an invalid lane.
        disp(2'b11, 8'h81, 8'h80, 5'd21, 5'd20); tick();
        disp(2'b11, 8'h91, 8'h90, 5'd23, 5'd22); tick();
        disp(2'b01, 8'hE1, 8'hE0, 5'd25, 5'd24); tick();
        idle();
        chk("num_three", 32'(num_rows), 3);
        wbset(0, 0, 0, 1'b0); wbset(1, 1, 1, 1'b0); wbset(2, 2, 0, 1'b0); tick();
        chk("cen_mwb", 32'(commit_en), 0);
        idle(); wbset(0, 2, 1, 1'b1); tick();
        chk("cen_inv", 32'(commit_en), 0);
        idle(); wbset(0, 0, 1, 1'b0); tick();
        chk("cen_r0_wait", 32'(commit_en), 0);
        idle(); tick();
        chk("cen_r0", 32'(commit_en), 3);
        chk("phys_r0", 32'(commit_phys_rd), 32'h8180);
        chk("arch_r0", 32'(commit_arch_rd), 32'h2B4);
        wbset(0, 1, 0, 1'b0); tick();
        chk("cen_r1_wait", 32'(commit_en), 0);
        idle(); tick();
        chk("cen_r1", 32'(commit_en), 3);
        chk("phys_r1", 32'(commit_phys_rd), 32'h9190);
        tick();
        chk("cen_r2", 32'(commit_en), 1);
        chk("phys_r2", 32'(commit_phys_rd[7:0]), 32'hE0);
        chk("arch_r2", 32'(commit_arch_rd[4:0]), 24);
        chk("excf_r2", 32'(exc_flush), 0);
        tick();
        chk("cen_r2_after", 32'(commit_en), 0);
        chk("excf_r2_after", 32'(exc_flush), 0);
        chk("empty_r2", 32'(empty), 1);
        chk("addr_r3", 32'(dispatch_rob_addr), 3);

        // Asynchronous reset with live contents and a commit on the outputs.
        disp(2'b11, 8'hC1, 8'hC0, 5'd27, 5'd26); tick();
        disp(2'b11, 8'hD1, 8'hD0, 5'd29, 5'd28); tick();
        idle(); wbset(0, 3, 0, 1'b0); wbset(1, 3, 1, 1'b0); tick();
        idle(); tick();
        chk("cen_pre_rst", 32'(commit_en), 3);
        chk("phys_pre_rst", 32'(commit_phys_rd), 32'hC1C0);
        chk("num_pre_rst", 32'(num_rows), 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_cen", 32'(commit_en), 0);
        chk("arst_phys", 32'(commit_phys_rd), 0);
        chk("arst_num", 32'(num_rows), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_ready", 32'(dispatch_ready), 1);
        chk("arst_addr", 32'(dispatch_rob_addr), 0);
        chk("arst_excf", 32'(exc_flush), 0);
        #5 rst = 1'b1;
        tick();
        chk("post_rst_cen", 32'(commit_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rob_banked.md
Name: rob_banked

Overview:
- Parametrised banked reorder buffer for the out-of-order core.
- Allocates one row of BANKS lanes per dispatch group and accepts completion from WB_PORTS independent writeback ports.
- Commits the oldest row in order once every valid lane in it is done.
- Adds real full/empty tracking, a ready/valid dispatch handshake, per-entry exception capture with precise partial-row commit, and external pipeline flush.
- Sits between rename/dispatch and the free-list/arch-map commit logic.

Parameters:
- ROB_DEPTH, 16, number of rows; power of two, minimum 2.
- BANKS, 2, lanes per row; equals dispatch and commit width.
- WB_PORTS, 3, writeback ports per cycle.
- PHYS_W, 8, physical register index width.
- ARCH_W, 5, architectural register index width.
- ROW_W, $clog2(ROB_DEPTH), row address width (derived).
- BANK_W, max(1,$clog2(BANKS)), lane address width (derived).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- dispatch_valid  input  BANKS  per-lane dispatch request; any lane set means the group is presented.
- dispatch_ready  output  1  high when a free row exists.
- dispatch_phys_rd  input  BANKS*PHYS_W  physical destination per lane.
- dispatch_arch_rd  input  BANKS*ARCH_W  architectural destination per lane.
- dispatch_rob_addr  output  ROW_W  row being allocated this cycle (combinational, equals tail).
- wb_en  input  WB_PORTS  writeback strobe per port.
- wb_rob_addr  input  WB_PORTS*ROW_W  target row.
- wb_bank  input  WB_PORTS*BANK_W  target lane.
- wb_exception  input  WB_PORTS  completing instruction raised an exception.
- commit_en  output  BANKS  per-lane commit strobe (registered).
- commit_phys_rd  output  BANKS*PHYS_W  committed physical destination.
- commit_arch_rd  output  BANKS*ARCH_W  committed architectural destination.
- flush_in  input  1  external flush, e.g. branch mispredict.
- exc_flush  output  1  one-cycle pulse when an exception reaches commit.
- exc_bank  output  BANK_W  lane of the excepting instruction, valid with exc_flush.
- empty  output  1  no rows occupied.
- num_rows  output  ROW_W+1  occupied row count, 0..ROB_DEPTH.

Behaviour:
- **Per-entry state:** valid, done, exc, phys_rd, arch_rd. head and tail are ROW_W-bit pointers that wrap modulo ROB_DEPTH. num_rows is a separate counter.
- **Reset (rst low, asynchronous):**
  - All valid, done and exc bits clear; head = tail = 0; num_rows = 0.
  - commit_en = 0, commit_phys_rd = 0, commit_arch_rd = 0, exc_flush = 0, exc_bank = 0.
  - Outputs therefore read dispatch_ready = 1 and empty = 1.
  - Reset mid-operation discards all contents.
- **Dispatch:**
  - A fire is |dispatch_valid && dispatch_ready && !flush_pending.
  - On a fire, the row at tail loads valid = dispatch_valid[w] per lane, with done = 0 and exc = 0, and tail increments.
  - Lanes with dispatch_valid = 0 stay invalid.
  - dispatch_ready = (num_rows != ROB_DEPTH). It does not depend on a same-cycle commit, so there is no bypass at full.
- **Writeback:**
  - Each port with wb_en sets done, and sets exc |= wb_exception, on its entry at the next edge.
  - Writeback to an invalid entry is ignored.
  - Several ports hitting distinct entries in the same cycle all take effect.
  - Two ports hitting the same entry OR their exc bits.
  - Writeback becomes visible to commit in the following cycle.
- **Commit (evaluated on the head row when num_rows > 0):**
  - Let k be the lowest lane with valid & done & exc, if one exists.
  - Normal: every valid lane is done and no exc is set. Register commit_en[w] = valid[w] with that lane's rd fields, clear the row, head++.
  - Exception: every valid lane below k is done. Commit those lanes only, with commit_en for lanes >= k forced to 0. Next cycle, pulse exc_flush = 1 with exc_bank = k. The excepting instruction itself is not committed.
  - Otherwise: commit_en = 0 and head holds.
- **num_rows:** +1 on dispatch only, -1 on commit only, unchanged when both occur in the same cycle.
- **Flush:**
  - flush_in, or the internal exception flush in the cycle exc_flush is asserted, clears every valid/done/exc bit and sets head = tail = 0, num_rows = 0.
  - It suppresses dispatch in that cycle.
  - commit_en is still driven for a commit decided in the preceding cycle, since it is already registered.
  - flush_pending is high from exception detection until the exc_flush cycle ends, which blocks further commits and dispatches.
- **Interaction:** flush_in has priority over a same-cycle dispatch and a same-cycle commit; no commit_en is produced from that cycle's evaluation.

Test Plan:
- Params DEPTH=4, BANKS=2, WB_PORTS=3. Dispatch rows 0..3 with lanes 11, 01, 11, 11 -> dispatch_rob_addr 0,1,2,3; num_rows 4; dispatch_ready = 0 on the 5th attempt; tail wraps to 0.
- Row 0, lane 1 written back before lane 0 -> no commit until lane 0 is done; the cycle after that writeback, commit_en = 2'b11 with the dispatched phys/arch values.
- Full ROB; same cycle, head row commits and a new group is presented -> the new group is not accepted (ready = 0). The next cycle it is accepted at row 0 (wrapped) and num_rows returns to 4.
- Row 0 lanes done with exc on lane 1 -> commit_en = 2'b01, then exc_flush = 1 with exc_bank = 1, then empty = 1, num_rows = 0, dispatch_rob_addr = 0.
- Three WB ports simultaneously targeting (0,0), (1,1), (2,0) plus one write to an invalid entry -> exactly those three become done and the invalid one is unchanged; commit order is still row 0, 1, 2.
- flush_in asserted together with a dispatch and a commit-ready head; rst pulsed low mid-stream -> flush: no dispatch, no commit_en from that cycle, empty the next cycle. Reset: all outputs return to reset values immediately, without a clock edge.
